// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Boot-time loader for the 24-bit CPU. Assembles a byte stream
//               into big-endian 24-bit words, writes them into instruction
//               memory, verifies a trailing XOR checksum byte and keeps the
//               CPU in reset until a load has completed successfully.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_length,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_imem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [23:0]           o_imem_wr_data,
  output logic                  o_cpu_reset,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH:0] c_mem_depth = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_zero_len  = '0;
  localparam logic [ADDR_WIDTH:0] c_one_len   = (ADDR_WIDTH+1)'(1);
  localparam logic [1:0]          c_last_byte = 2'd2;

  state_t                r_state;
  logic [1:0]            r_byte_cnt;
  logic [ADDR_WIDTH:0]   r_words_left;
  logic [7:0]            r_csum;
  logic                  r_rx_ready;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [23:0]           r_wr_data;
  logic                  r_cpu_reset;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic [ADDR_WIDTH:0]   w_len_clamped;
  logic                  w_rx_fire;

  // Oversized requests are clamped so the address never wraps inside a load.
  assign w_len_clamped = (i_length > c_mem_depth) ? c_mem_depth : i_length;
  assign w_rx_fire     = i_rx_valid && r_rx_ready;

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_byte_cnt   <= 2'd0;
      r_words_left <= '0;
      r_csum       <= 8'h00;
      r_rx_ready   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= 24'h000000;
      r_cpu_reset  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_words_left <= w_len_clamped;
            r_byte_cnt   <= 2'd0;
            r_addr       <= '0;
            r_csum       <= 8'h00;
            r_wr_data    <= 24'h000000;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b1;
            r_rx_ready   <= 1'b1;
            // A zero-length load still consumes the checksum byte.
            r_state      <= (w_len_clamped == c_zero_len) ? S_CHECK : S_LOAD;
          end
        end

        S_LOAD: begin
          if (w_rx_fire) begin
            r_csum    <= r_csum ^ i_rx_data;
            r_wr_data <= {r_wr_data[15:0], i_rx_data};
            if (r_byte_cnt == c_last_byte) begin
              // Drop ready now so the source holds the next byte during WRITE.
              r_byte_cnt <= 2'd0;
              r_rx_ready <= 1'b0;
              r_wr_en    <= 1'b1;
              r_state    <= S_WRITE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end

        S_WRITE: begin
          r_wr_en      <= 1'b0;
          r_rx_ready   <= 1'b1;
          r_addr       <= r_addr + 1'b1;
          r_words_left <= r_words_left - 1'b1;
          r_state      <= (r_words_left == c_one_len) ? S_CHECK : S_LOAD;
        end

        S_CHECK: begin
          if (w_rx_fire) begin
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (i_rx_data == r_csum) begin
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_error     <= 1'b1;
              r_cpu_reset <= 1'b1;
              r_state     <= S_ERROR;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rx_ready     = r_rx_ready;
  assign o_imem_wr_en   = r_wr_en;
  assign o_imem_addr    = r_addr;
  assign o_imem_wr_data = r_wr_data;
  assign o_cpu_reset    = r_cpu_reset;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Scoreboard bench for instr_mem_loader. Stimulus pushes the
//               expected memory writes into a queue; a monitor pops and
//               compares on every write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [8:0]  i_length;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        o_imem_wr_en;
  logic [7:0]  o_imem_addr;
  logic [23:0] o_imem_wr_data;
  logic        o_cpu_reset;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;
  logic [31:0] exp_q[$];

  instr_mem_loader #(
    .ADDR_WIDTH (8),
    .MEM_DEPTH  (256)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_length       (i_length),
    .i_rx_data      (i_rx_data),
    .i_rx_valid     (i_rx_valid),
    .o_rx_ready     (o_rx_ready),
    .o_imem_wr_en   (o_imem_wr_en),
    .o_imem_addr    (o_imem_addr),
    .o_imem_wr_data (o_imem_wr_data),
    .o_cpu_reset    (o_cpu_reset),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (o_imem_wr_en) begin
        n_writes++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                   o_imem_addr, o_imem_wr_data);
        end else begin
          exp = exp_q.pop_front();
          if ({o_imem_addr, o_imem_wr_data} !== exp) begin
            n_errors++;
            $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                     o_imem_addr, o_imem_wr_data, exp[31:24], exp[23:0]);
          end
        end
      end
    end
  end

  // Status vector order: {rx_ready, wr_en, cpu_reset, busy, done, error}
  task automatic check_status(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {o_rx_ready, o_imem_wr_en, o_cpu_reset, o_busy, o_done, o_error};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got status=%b, required %b", name, act, exp);
    end
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s: got %0d pending writes, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_count(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) @(negedge clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    waited     = 0;
    while (!o_rx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!o_rx_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL rx_timeout: got ready=0 after %0d cycles, required ready=1", waited);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [23:0] w, input int max_gap);
    exp_q.push_back({addr, w});
    send_byte(w[23:16], $urandom_range(0, max_gap));
    send_byte(w[15:8],  $urandom_range(0, max_gap));
    send_byte(w[7:0],   $urandom_range(0, max_gap));
  endtask

  task automatic start_load(input logic [8:0] len);
    i_start  = 1'b1;
    i_length = len;
    @(negedge clk);
    i_start  = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  csum;
    logic [23:0] w;
    int          base;

    rst        = 1'b1;
    i_start    = 1'b0;
    i_length   = 9'd0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;

    // Test 1: reset values
    repeat (2) @(negedge clk);
    check_status("reset_state", 6'b001000);
    rst = 1'b0;
    @(negedge clk);
    check_status("idle_after_reset", 6'b001000);

    // Test 2: two-word load with correct checksum
    start_load(9'd2);
    check_status("load_busy", 6'b101100);
    send_word(8'h00, 24'h123456, 0);
    send_word(8'h01, 24'hABCDEF, 0);
    send_byte(8'hF9, 0);
    check_drained("t2_writes");
    check_status("t2_done", 6'b000010);

    // Test 3: bad checksum, then reload
    start_load(9'd2);
    send_word(8'h00, 24'h123456, 0);
    send_word(8'h01, 24'hABCDEF, 0);
    send_byte(8'h00, 0);
    check_drained("t3_writes");
    check_status("t3_error", 6'b001001);
    repeat (3) @(negedge clk);
    check_status("t3_error_held", 6'b001001);
    start_load(9'd2);
    send_word(8'h00, 24'h123456, 0);
    send_word(8'h01, 24'hABCDEF, 0);
    send_byte(8'hF9, 0);
    check_drained("t3_reload_writes");
    check_status("t3_reload_done", 6'b000010);

    // Test 4: gapped stream, checksum byte offered during WRITE
    start_load(9'd1);
    send_word(8'h00, 24'hA1B2C3, 3);
    send_byte(8'hD0, 0);
    check_drained("t4_writes");
    check_status("t4_done", 6'b000010);

    // Test 5: reset after two bytes, then a clean load
    base = n_writes;
    start_load(9'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_status("t5_reset_mid_word", 6'b001000);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_count("t5_no_write_after_reset", n_writes - base, 0);
    start_load(9'd1);
    send_word(8'h00, 24'h010203, 0);
    send_byte(8'h00, 0);
    check_drained("t5_writes");
    check_status("t5_done", 6'b000010);

    // Test 6a: zero-length load
    base = n_writes;
    start_load(9'd0);
    check_status("t6_zero_busy", 6'b101100);
    send_byte(8'h00, 0);
    check_count("t6_zero_writes", n_writes - base, 0);
    check_status("t6_zero_done", 6'b000010);

    // Test 6b: Length=300 clamps to 256 words ending at address 0xFF
    base = n_writes;
    csum = 8'h00;
    start_load(9'd300);
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(i) ^ 8'hFF, 8'(i) + 8'h37};
      csum = csum ^ w[23:16] ^ w[15:8] ^ w[7:0];
      send_word(8'(i), w, 0);
    end
    send_byte(csum, 0);
    check_drained("t6_clamp_writes");
    check_count("t6_clamp_count", n_writes - base, 256);
    check_status("t6_clamp_done", 6'b000010);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Boot-time loader that sits directly upstream of the 24-bit single-cycle CPU.
- Receives a byte stream over a valid/ready handshake and assembles each group of three bytes into a 24-bit instruction word.
- Writes each word into the instruction memory write port, then checks a trailing XOR checksum byte.
- Holds the CPU in reset for the whole load and releases it only after a successful load.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width.
- MEM_DEPTH, 256, number of instruction words; must equal 2**ADDR_WIDTH.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- Length  in  ADDR_WIDTH+1  number of words to load; sampled on the Start cycle.
- RxData  in  8  stream byte.
- RxValid  in  1  RxData is valid.
- RxReady  out  1  loader accepts a byte; a transfer occurs when RxValid and RxReady are both high.
- IMemWrEn  out  1  instruction memory write strobe.
- IMemAddr  out  ADDR_WIDTH  write address.
- IMemWrData  out  24  write data.
- CpuReset  out  1  reset to the CPU; high except in DONE.
- Busy  out  1  high in LOAD, WRITE and CHECK.
- Done  out  1  load succeeded.
- Error  out  1  checksum mismatch.

Behaviour:
- All outputs are registered. Values after Reset:
  - RxReady=0, IMemWrEn=0, IMemAddr=0, IMemWrData=0.
  - CpuReset=1, Busy=0, Done=0, Error=0.
  - state=IDLE, byte counter=0, words_left=0, checksum=0.
- States are IDLE, LOAD, WRITE, CHECK, DONE and ERROR.
- Start accepted in IDLE, DONE or ERROR:
  - Latch words_left = min(Length, MEM_DEPTH).
  - Clear byte counter, address and checksum; clear Done and Error; set CpuReset=1.
  - If the latched value is 0, go to CHECK; otherwise go to LOAD.
- Start in LOAD, WRITE or CHECK is ignored.
- LOAD:
  - RxReady=1.
  - Each accepted byte is XORed into the 8-bit checksum and shifted into the word, big-endian: byte0 goes to [23:16], byte1 to [15:8], byte2 to [7:0].
  - The byte counter runs 0 to 2. Acceptance of byte2 moves the FSM to WRITE.
- WRITE, exactly one cycle:
  - RxReady=0, IMemWrEn=1, with IMemAddr and IMemWrData holding the current address and assembled word.
  - On leaving WRITE: address+1 and words_left-1.
  - If words_left reaches 0, go to CHECK; otherwise go to LOAD.
  - A byte presented during WRITE is held by the source (RxReady=0) and is not lost.
- Latency and throughput:
  - If byte2 is accepted on edge k, IMemWrEn is high in the cycle after edge k.
  - Peak throughput is one word per 4 cycles.
- CHECK:
  - RxReady=1. The accepted byte is compared with the running checksum.
  - Equal: go to DONE. Unequal: go to ERROR.
  - The checksum byte is never written to memory.
- DONE: Done=1, CpuReset=0, RxReady=0; held until Start or Reset.
- ERROR: Error=1, CpuReset=1, RxReady=0; held until Start or Reset.
- Address wrap: at most MEM_DEPTH words are written, so IMemAddr never wraps within a load.
- Length greater than MEM_DEPTH is silently clamped to MEM_DEPTH.
- Reset at any point, including mid-word or mid-write:
  - Return to IDLE and discard any partial word.
  - No further write strobes; memory already written is left as is.
- Reset and Start in the same cycle: Reset wins.
- IMemWrEn is never high outside WRITE.

Test Plan:
1. Reset held 2 cycles -> RxReady=0, IMemWrEn=0, CpuReset=1, Done=0, Error=0, Busy=0.
2. Start with Length=2; stream 12 34 56 AB CD EF F9 -> addr0=0x123456 and addr1=0xABCDEF, one IMemWrEn pulse each. Then Done=1, CpuReset=0, Busy=0.
3. Same stream with checksum byte 00 -> both words still written; Error=1, Done=0, CpuReset stays 1. Start then reloads correctly to Done.
4. Length=1; RxValid gapped randomly and a byte offered during WRITE -> word 0xA1B2C3 written to addr0, no byte dropped or duplicated. Checksum A1^B2^C3=0xD0 gives Done.
5. Reset asserted after 2 of 3 bytes -> IDLE, no IMemWrEn. A following Start with Length=1 and bytes 01 02 03 00 -> addr0=0x010203, Done=1.
6. Length=0 then checksum 00 -> no writes, Done=1. Length=300 -> clamps to 256 words, with the last write at addr 0xFF.
